hazard_forward_ctrl: RTL and testbench
======================================

# hazard_forward_ctrl

Pipeline hazard controller for the LEGv8 5-stage core. It keeps a shadow copy of the destination-register state of the ID/EX, EX/MEM and MEM/WB stages and drives the two EX-stage operand forwarding muxes (64-bit 3:1, select 2 bits) through registered select codes. It also detects load-use hazards and generates the stall and bubble controls, plus the flushes on a taken branch. Saturating stall and flush counters are kept for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  ID stage holds a real instruction.
- id_rn  in  5  first source register of the ID instruction.
- id_rn_used  in  1  id_rn is actually read.
- id_rm  in  5  second source register (Rm or Rt).
- id_rm_used  in  1  id_rm is actually read.
- id_rd  in  5  destination register of the ID instruction.
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load (LDUR).
- br_taken  in  1  branch resolved taken in MEM this cycle.
- forward_a  out  2  select for the EX operand-A mux.
- forward_b  out  2  select for the EX operand-B mux.
- stall  out  1  hold PC and IF/ID this cycle.
- bubble_id_ex  out  1  load zeros (NOP controls) into ID/EX this edge.
- flush_if_id  out  1  clear IF/ID.
- flush_id_ex  out  1  clear ID/EX.
- flush_ex_mem  out  1  clear EX/MEM.
- stall_count  out  CNT_W  number of stall cycles, saturating.
- flush_count  out  CNT_W  number of taken-branch flushes, saturating.

## Operation
- Select codes:
  - 00 = register-file value.
  - 01 = MEM/WB write-back data.
  - 10 = EX/MEM ALU result.
  - 11 is never driven.
- Shadows. Each stage shadow holds {valid, rd, reg_write, mem_read}. Every edge they advance ID→EX→MEM→WB, with these exceptions:
  - EX shadow loads zeros when bubble_id_ex or flush_id_ex is asserted.
  - MEM shadow loads zeros when flush_ex_mem is asserted.
- Forward select for source s (rn→forward_a, rm→forward_b). It is computed from the ID instruction and registered at the edge that moves that instruction into EX. The first matching rule wins:
  - s_used, s≠31, and the EX shadow has reg_write with rd==s → 10.
  - s_used, s≠31, and the MEM shadow has reg_write with rd==s → 01.
  - Otherwise → 00.
- The registered selects are forced to 00 when the ID instruction is not advancing: id_valid=0, a bubble, or a flush.
- Load-use hazard:
  - Condition: EX shadow valid and mem_read, its rd≠31, and rd equals id_rn (with id_rn_used) or id_rm (with id_rm_used), with id_valid=1.
  - Response: stall=1 and bubble_id_ex=1 for exactly one cycle. On the following cycle the load is in MEM, so the dependent instruction forwards with 01.
- Taken branch (br_taken=1):
  - flush_if_id, flush_id_ex and flush_ex_mem are all 1 in the same cycle.
  - stall and bubble_id_ex are forced to 0 (the flush has priority).
  - flush_count increments by 1.
- stall_count increments on every cycle with stall=1. Both counters hold at all-ones once saturated.
- X31 (XZR) is never a forwarding source and never a hazard.

## Timing
- stall, bubble_id_ex and all flush outputs are combinational from the inputs and current shadows, valid in the same cycle.
- forward_a and forward_b are registered with 1-cycle latency: they are valid during the EX cycle of the instruction they belong to.
- Reset (asynchronous, any time, including mid-stall or mid-flush):
  - All shadows invalid/zero.
  - forward_a and forward_b = 00.
  - stall_count and flush_count = 0.
  - Combinational outputs = 0 once the shadows are cleared.
- Simultaneous load-use hazard and br_taken: only the flush takes effect and stall_count does not increment.
- No hazard produces more than one stall cycle.

## Structure
- Package legv8_hazard_pkg holds:
  - Constants FWD_REGFILE=2'b00, FWD_WB=2'b01, FWD_EXMEM=2'b10, XZR=5'd31.
  - Typedef stage_shadow_t {valid, rd[4:0], reg_write, mem_read}.
- Sub-module hazard_stage_reg: one shadow register with a synchronous clear input and asynchronous reset. It is instantiated three times (EX, MEM, WB).
- Forwarding priority, hazard detection and counters live in the top module.

## Test plan
- ADD X1,.. then SUB X2,X1,X3 back-to-back → forward_a=10 during SUB's EX cycle, forward_b=00, no stall.
- ADD X1,..; NOP; ORR X4,X5,X1 → forward_b=01 during ORR's EX cycle.
- LDUR X2,[..] then ADD X3,X2,X2 → stall=1 and bubble_id_ex=1 for one cycle, then forward_a=forward_b=01 during ADD's EX cycle; stall_count=1.
- ADD X31,.. then SUB X6,X31,X7 → forward_a=00 and no stall; load into X31 followed by a use → no stall.
- br_taken=1 in the same cycle as a load-use condition → all three flushes=1, stall=0, flush_count=1, stall_count unchanged.
- Reset asserted during a stall cycle → stall=0, forward selects 00 and counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/legv8_hazard_pkg.sv
// Shared types and constants for the LEGv8 hazard / forwarding controller.
package legv8_hazard_pkg;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_WB      = 2'b01;
   localparam logic [1:0] FWD_EXMEM   = 2'b10;
   localparam logic [4:0] XZR         = 5'd31;

   // Destination-register state tracked for one pipeline stage.
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
   } stage_shadow_t;

   // Forward-select for one source operand. The nearer producer (EX) wins
   // over the older one (MEM); XZR is never produced, so it never forwards.
   function automatic logic [1:0] fwd_select(input logic          used,
                                             input logic [4:0]    src,
                                             input stage_shadow_t ex,
                                             input stage_shadow_t mem);
      logic [1:0] sel;
      sel = FWD_REGFILE;
      if (used && (src != XZR)) begin
         if (ex.valid && ex.reg_write && (ex.rd == src)) begin
            sel = FWD_EXMEM;
         end else if (mem.valid && mem.reg_write && (mem.rd == src)) begin
            sel = FWD_WB;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage shadow register: async reset, sync clear, else load.
module hazard_stage_reg
   import legv8_hazard_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_i,
   input  stage_shadow_t d_i,
   output stage_shadow_t q_o
);

   stage_shadow_t shadow_q;

   // Advance the shadow every edge; a clear turns the stage into a bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q <= '0;
      end else if (clear_i) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= d_i;
      end
   end

   assign q_o = shadow_q;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// LEGv8 5-stage hazard controller: EX operand forwarding selects, load-use
// stall/bubble, taken-branch flushes and saturating performance counters.
module hazard_forward_ctrl
   import legv8_hazard_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rn,
   input  logic             id_rn_used,
   input  logic [4:0]       id_rm,
   input  logic             id_rm_used,
   input  logic [4:0]       id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             br_taken,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b,
   output logic             stall,
   output logic             bubble_id_ex,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             flush_ex_mem,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   stage_shadow_t id_s;
   stage_shadow_t ex_q;
   stage_shadow_t mem_q;
   // The WB shadow is kept for debug visibility; no control path reads it,
   // because the MEM/WB select is decided while the producer is still in MEM.
   stage_shadow_t wb_shadow_unused;

   logic             load_use;
   logic             advance;
   logic [1:0]       fwd_a_d, fwd_a_q;
   logic [1:0]       fwd_b_d, fwd_b_q;
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

   assign id_s = '{valid: id_valid, rd: id_rd,
                   reg_write: id_reg_write, mem_read: id_mem_read};

   hazard_stage_reg u_ex_shadow (
      .clk     (clk),
      .reset   (reset),
      .clear_i (bubble_id_ex | flush_id_ex),
      .d_i     (id_s),
      .q_o     (ex_q)
   );

   hazard_stage_reg u_mem_shadow (
      .clk     (clk),
      .reset   (reset),
      .clear_i (flush_ex_mem),
      .d_i     (ex_q),
      .q_o     (mem_q)
   );

   hazard_stage_reg u_wb_shadow (
      .clk     (clk),
      .reset   (reset),
      .clear_i (1'b0),
      .d_i     (mem_q),
      .q_o     (wb_shadow_unused)
   );

   // Load-use detection, with the taken-branch flush overriding the stall.
   always_comb begin
      load_use = 1'b0;
      if (id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != XZR)) begin
         load_use = (id_rn_used && (id_rn == ex_q.rd)) ||
                    (id_rm_used && (id_rm == ex_q.rd));
      end
      flush_if_id  = br_taken;
      flush_id_ex  = br_taken;
      flush_ex_mem = br_taken;
      stall        = load_use && !br_taken;
      bubble_id_ex = load_use && !br_taken;
   end

   // Next forward selects for the ID instruction; 00 if it will not enter EX.
   always_comb begin
      advance = id_valid && !bubble_id_ex && !flush_id_ex;
      fwd_a_d = FWD_REGFILE;
      fwd_b_d = FWD_REGFILE;
      if (advance) begin
         fwd_a_d = fwd_select(id_rn_used, id_rn, ex_q, mem_q);
         fwd_b_d = fwd_select(id_rm_used, id_rm, ex_q, mem_q);
      end
   end

   // Saturating counters: hold once all-ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (br_taken && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   // Register forward selects and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fwd_a_q     <= FWD_REGFILE;
         fwd_b_q     <= FWD_REGFILE;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign forward_a   = fwd_a_q;
   assign forward_b   = fwd_b_q;
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed, table-driven bench for hazard_forward_ctrl. Counters are built
// narrow so saturation can be reached in a short run.
module tb_hazard_forward_ctrl;

   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic             id_valid;
   logic [4:0]       id_rn;
   logic             id_rn_used;
   logic [4:0]       id_rm;
   logic             id_rm_used;
   logic [4:0]       id_rd;
   logic             id_reg_write;
   logic             id_mem_read;
   logic             br_taken;
   logic [1:0]       forward_a;
   logic [1:0]       forward_b;
   logic             stall;
   logic             bubble_id_ex;
   logic             flush_if_id;
   logic             flush_id_ex;
   logic             flush_ex_mem;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       v;
      logic [4:0] rn;
      logic       rnu;
      logic [4:0] rm;
      logic       rmu;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
      logic       br;
      logic       exp_stall;
      logic       exp_flush;
      logic [1:0] exp_fa;
      logic [1:0] exp_fb;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs[NVEC];

   hazard_forward_ctrl #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_rn        (id_rn),
      .id_rn_used   (id_rn_used),
      .id_rm        (id_rm),
      .id_rm_used   (id_rm_used),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .br_taken     (br_taken),
      .forward_a    (forward_a),
      .forward_b    (forward_b),
      .stall        (stall),
      .bubble_id_ex (bubble_id_ex),
      .flush_if_id  (flush_if_id),
      .flush_id_ex  (flush_id_ex),
      .flush_ex_mem (flush_ex_mem),
      .stall_count  (stall_count),
      .flush_count  (flush_count)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic v, input logic [4:0] rn, input logic rnu,
                               input logic [4:0] rm, input logic rmu, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic br,
                               input logic es, input logic ef,
                               input logic [1:0] fa, input logic [1:0] fb);
      vec_t t;
      t.v = v; t.rn = rn; t.rnu = rnu; t.rm = rm; t.rmu = rmu; t.rd = rd;
      t.rw = rw; t.mr = mr; t.br = br;
      t.exp_stall = es; t.exp_flush = ef; t.exp_fa = fa; t.exp_fb = fb;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t t);
      id_valid     = t.v;
      id_rn        = t.rn;
      id_rn_used   = t.rnu;
      id_rm        = t.rm;
      id_rm_used   = t.rmu;
      id_rd        = t.rd;
      id_reg_write = t.rw;
      id_mem_read  = t.mr;
      br_taken     = t.br;
   endtask

   task automatic driveIdle();
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
   endtask

   initial begin
      // Program: each row is the instruction in ID that cycle; expected
      // selects belong to the instruction currently in EX.
      //             v  rn rnu rm rmu rd rw mr br  st fl  fa     fb
      vecs[0]  = mk(1,  2, 1,  3, 1,  1, 1, 0, 0,  0, 0, 2'b00, 2'b00); // ADD X1,X2,X3
      vecs[1]  = mk(1,  1, 1,  3, 1,  2, 1, 0, 0,  0, 0, 2'b00, 2'b00); // SUB X2,X1,X3
      vecs[2]  = mk(1,  5, 1,  6, 1,  1, 1, 0, 0,  0, 0, 2'b10, 2'b00); // ADD X1,X5,X6
      vecs[3]  = mk(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 2'b00, 2'b00); // NOP
      vecs[4]  = mk(1,  5, 1,  1, 1,  4, 1, 0, 0,  0, 0, 2'b00, 2'b00); // ORR X4,X5,X1
      vecs[5]  = mk(1,  9, 1,  0, 0,  2, 1, 1, 0,  0, 0, 2'b00, 2'b01); // LDUR X2,[X9]
      vecs[6]  = mk(1,  2, 1,  2, 1,  3, 1, 0, 0,  1, 0, 2'b00, 2'b00); // ADD X3,X2,X2 (stall)
      vecs[7]  = mk(1,  2, 1,  2, 1,  3, 1, 0, 0,  0, 0, 2'b00, 2'b00); // ADD X3,X2,X2 (held)
      vecs[8]  = mk(1,  1, 1,  1, 1, 31, 1, 0, 0,  0, 0, 2'b01, 2'b01); // ADD X31,X1,X1
      vecs[9]  = mk(1, 31, 1,  7, 1,  6, 1, 0, 0,  0, 0, 2'b00, 2'b00); // SUB X6,X31,X7
      vecs[10] = mk(1,  1, 1,  0, 0, 31, 1, 1, 0,  0, 0, 2'b00, 2'b00); // LDUR X31,[X1]
      vecs[11] = mk(1, 31, 1, 31, 1,  8, 1, 0, 0,  0, 0, 2'b00, 2'b00); // ADD X8,X31,X31
      vecs[12] = mk(1,  8, 1,  0, 0,  5, 1, 1, 0,  0, 0, 2'b00, 2'b00); // LDUR X5,[X8]
      vecs[13] = mk(1,  5, 1,  0, 1,  9, 1, 0, 1,  0, 1, 2'b10, 2'b00); // ADD X9,X5,X0 + branch
      vecs[14] = mk(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 2'b00, 2'b00); // NOP after flush

      reset = 1'b1;
      driveIdle();
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_forward_a", 32'(forward_a), 32'd0);
      checkOutput("reset_forward_b", 32'(forward_b), 32'd0);
      checkOutput("reset_stall", 32'(stall), 32'd0);
      checkOutput("reset_stall_count", 32'(stall_count), 32'd0);
      checkOutput("reset_flush_count", 32'(flush_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Main program table.
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
         checkOutput($sformatf("v%0d_bubble", i), 32'(bubble_id_ex), 32'(vecs[i].exp_stall));
         checkOutput($sformatf("v%0d_flush_if_id", i), 32'(flush_if_id), 32'(vecs[i].exp_flush));
         checkOutput($sformatf("v%0d_flush_id_ex", i), 32'(flush_id_ex), 32'(vecs[i].exp_flush));
         checkOutput($sformatf("v%0d_flush_ex_mem", i), 32'(flush_ex_mem), 32'(vecs[i].exp_flush));
         checkOutput($sformatf("v%0d_forward_a", i), 32'(forward_a), 32'(vecs[i].exp_fa));
         checkOutput($sformatf("v%0d_forward_b", i), 32'(forward_b), 32'(vecs[i].exp_fb));
      end
      checkOutput("prog_stall_count", 32'(stall_count), 32'd1);
      checkOutput("prog_flush_count", 32'(flush_count), 32'd1);

      // Asynchronous reset in the middle of a stall cycle.
      @(negedge clk);
      applyStimulus(mk(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00)); // ADD X1,X2,X3
      @(negedge clk);
      applyStimulus(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, 2'b00, 2'b00)); // LDUR X7,[X1]
      @(negedge clk);
      applyStimulus(mk(1, 7, 1, 0, 1, 8, 1, 0, 0, 0, 0, 2'b00, 2'b00)); // ADD X8,X7,X0
      #1;
      checkOutput("pre_reset_stall", 32'(stall), 32'd1);
      checkOutput("pre_reset_forward_a", 32'(forward_a), 32'd2);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_stall", 32'(stall), 32'd0);
      checkOutput("async_reset_bubble", 32'(bubble_id_ex), 32'd0);
      checkOutput("async_reset_forward_a", 32'(forward_a), 32'd0);
      checkOutput("async_reset_forward_b", 32'(forward_b), 32'd0);
      checkOutput("async_reset_stall_count", 32'(stall_count), 32'd0);
      checkOutput("async_reset_flush_count", 32'(flush_count), 32'd0);
      @(negedge clk);
      driveIdle();
      reset = 1'b0;

      // Flush counter saturation: 20 taken branches into a 4-bit counter.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
      end
      @(negedge clk);
      driveIdle();
      #1;
      checkOutput("flush_count_saturated", 32'(flush_count), 32'd15);

      // Stall counter saturation: 17 load-use pairs, one stall cycle each.
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         applyStimulus(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, 2'b00, 2'b00));
         @(negedge clk);
         applyStimulus(mk(1, 7, 1, 0, 1, 8, 1, 0, 0, 0, 0, 2'b00, 2'b00));
         @(negedge clk);
      end
      @(negedge clk);
      driveIdle();
      #1;
      checkOutput("stall_count_saturated", 32'(stall_count), 32'd15);
      checkOutput("flush_count_held", 32'(flush_count), 32'd15);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
